// File: rtl/wr_arbiter.sv
// rtl/wr_arbiter.sv - two-producer write arbiter feeding the CDC buffer write port
module wr_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_1,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             fib_valid,
    input  logic [15:0]      fib_data,
    output logic             fib_ready,
    input  logic             tmr_valid,
    input  logic [15:0]      tmr_data,
    output logic             tmr_ready,
    input  logic             buffer_full,
    output logic             data_1_en,
    output logic [15:0]      data_1,
    output logic [1:0]       grant,
    output logic             stall,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             last_tmr_q, last_tmr_d;
    logic [15:0]      data_q, data_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic fib_req, tmr_req, pick_fib, pick_tmr, can_accept, accept;

    always_comb begin
        fib_req    = mode[0] & fib_valid;
        tmr_req    = mode[1] & tmr_valid;
        // On a tie the source that did not win last time takes the slot.
        pick_fib   = fib_req & (~tmr_req | last_tmr_q);
        pick_tmr   = tmr_req & ~pick_fib;
        can_accept = (state_q == ARB) & ~buffer_full;
        fib_ready  = can_accept & pick_fib;
        tmr_ready  = can_accept & pick_tmr;
        accept     = fib_ready | tmr_ready;
    end

    always_comb begin
        state_d       = state_q;
        last_tmr_d    = last_tmr_q;
        data_d        = data_q;
        grant_d       = grant_q;
        word_count_d  = word_count_q;
        stall_count_d = stall_count_q;

        if (accept) begin
            last_tmr_d   = tmr_ready;
            data_d       = fib_ready ? fib_data : tmr_data;
            grant_d      = {tmr_ready, fib_ready};
            word_count_d = word_count_q + CNT_ONE;
        end
        if (state_q == HOLD && stall_count_q != '1) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (mode != 2'b00) state_d = ARB;
            end
            ARB: begin
                if (mode == 2'b00)                        state_d = IDLE;
                else if (buffer_full && (fib_req || tmr_req)) state_d = HOLD;
                else if (accept)                          state_d = WRITE;
            end
            WRITE: begin
                state_d = (mode == 2'b00) ? IDLE : ARB;
            end
            HOLD: begin
                if (mode == 2'b00)     state_d = IDLE;
                else if (!buffer_full) state_d = ARB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_tmr_q    <= 1'b1;
            data_q        <= '0;
            grant_q       <= '0;
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_tmr_q    <= last_tmr_d;
            data_q        <= data_d;
            grant_q       <= grant_d;
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // WRITE lasts exactly one cycle, which also blocks accepts while the write is in flight.
    assign data_1_en   = (state_q == WRITE);
    assign stall       = (state_q == HOLD);
    assign data_1      = data_q;
    assign grant       = grant_q;
    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_wr_arbiter.sv
// tb/tb_wr_arbiter.sv - directed self-checking bench for wr_arbiter
module tb_wr_arbiter;

    logic        clk_1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        fib_valid = 1'b0;
    logic [15:0] fib_data = 16'h0;
    logic        tmr_valid = 1'b0;
    logic [15:0] tmr_data = 16'h0;
    logic        buffer_full = 1'b0;

    logic        fib_ready, tmr_ready, data_1_en, stall;
    logic [15:0] data_1;
    logic [1:0]  grant;
    logic [15:0] word_count, stall_count;

    logic        n_fib_ready, n_tmr_ready, n_data_1_en, n_stall;
    logic [15:0] n_data_1;
    logic [1:0]  n_grant;
    logic [3:0]  n_word_count, n_stall_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    wr_arbiter #(.CNT_W(16)) dut (
        .clk_1(clk_1), .rst_n(rst_n), .mode(mode),
        .fib_valid(fib_valid), .fib_data(fib_data), .fib_ready(fib_ready),
        .tmr_valid(tmr_valid), .tmr_data(tmr_data), .tmr_ready(tmr_ready),
        .buffer_full(buffer_full), .data_1_en(data_1_en), .data_1(data_1),
        .grant(grant), .stall(stall), .word_count(word_count), .stall_count(stall_count)
    );

    // Narrow counters make saturation reachable in a few cycles.
    wr_arbiter #(.CNT_W(4)) dut_n (
        .clk_1(clk_1), .rst_n(rst_n), .mode(mode),
        .fib_valid(fib_valid), .fib_data(fib_data), .fib_ready(n_fib_ready),
        .tmr_valid(tmr_valid), .tmr_data(tmr_data), .tmr_ready(n_tmr_ready),
        .buffer_full(buffer_full), .data_1_en(n_data_1_en), .data_1(n_data_1),
        .grant(n_grant), .stall(n_stall), .word_count(n_word_count), .stall_count(n_stall_count)
    );

    initial forever #5 clk_1 = ~clk_1;

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mode = 2'b00; fib_valid = 1'b0; tmr_valid = 1'b0;
        buffer_full = 1'b0; fib_data = 16'h0; tmr_data = 16'h0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++; if (data_1_en !== 1'b0) $display("FAIL rst_en: got %b want 0", data_1_en); else pass_cnt++;
        total_cnt++; if (data_1 !== 16'h0) $display("FAIL rst_data: got %h want 0000", data_1); else pass_cnt++;
        total_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
        total_cnt++; if (word_count !== 16'h0 || stall_count !== 16'h0)
            $display("FAIL rst_counts: got %h/%h want 0000/0000", word_count, stall_count); else pass_cnt++;
        total_cnt++; if (fib_ready !== 1'b0 || tmr_ready !== 1'b0)
            $display("FAIL rst_ready: got %b%b want 00", fib_ready, tmr_ready); else pass_cnt++;
    endtask

    task automatic test_single_fib();
        mode = 2'b01; fib_valid = 1'b1; fib_data = 16'h0005;
        #1;
        total_cnt++; if (fib_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", fib_ready); else pass_cnt++;
        tick();
        total_cnt++; if (fib_ready !== 1'b1) $display("FAIL fib_ready: got %b want 1", fib_ready); else pass_cnt++;
        tick();
        fib_valid = 1'b0;
        total_cnt++; if (data_1_en !== 1'b1 || data_1 !== 16'h0005 || grant !== 2'b01)
            $display("FAIL fib_write: got en=%b d=%h g=%b want en=1 d=0005 g=01", data_1_en, data_1, grant); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd1) $display("FAIL fib_wc: got %0d want 1", word_count); else pass_cnt++;
        tick();
        total_cnt++; if (data_1_en !== 1'b0 || data_1 !== 16'h0005 || grant !== 2'b01)
            $display("FAIL fib_hold: got en=%b d=%h g=%b want en=0 d=0005 g=01", data_1_en, data_1, grant); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic        exp_en;
        logic [1:0]  exp_g;
        logic [15:0] exp_d;
        logic        prev_en;
        do_reset();
        mode = 2'b11; fib_valid = 1'b1; fib_data = 16'h0001; tmr_valid = 1'b1; tmr_data = 16'h00AA;
        tick();
        prev_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_en = (i % 2 == 0);
            exp_g  = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h00AA;
            total_cnt++; if (data_1_en !== exp_en) $display("FAIL rr_en[%0d]: got %b want %b", i, data_1_en, exp_en); else pass_cnt++;
            if (exp_en) begin
                total_cnt++; if (grant !== exp_g || data_1 !== exp_d)
                    $display("FAIL rr_word[%0d]: got g=%b d=%h want g=%b d=%h", i, grant, data_1, exp_g, exp_d); else pass_cnt++;
            end
            total_cnt++; if (prev_en && data_1_en) $display("FAIL rr_spacing[%0d]: got back-to-back en want gap", i); else pass_cnt++;
            prev_en = data_1_en;
        end
        total_cnt++; if (word_count !== 16'd4) $display("FAIL rr_wc: got %0d want 4", word_count); else pass_cnt++;
        mode = 2'b00; fib_valid = 1'b0; tmr_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        mode = 2'b10; tmr_valid = 1'b1; tmr_data = 16'h00AA; buffer_full = 1'b1;
        tick();
        total_cnt++; if (tmr_ready !== 1'b0) $display("FAIL stall_arb_ready: got %b want 0", tmr_ready); else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) buffer_full = 1'b0;
            #1;
            total_cnt++; if (stall !== 1'b1 || tmr_ready !== 1'b0)
                $display("FAIL stall_hold[%0d]: got stall=%b rdy=%b want 1/0", i, stall, tmr_ready); else pass_cnt++;
        end
        tick();
        total_cnt++; if (stall !== 1'b0 || stall_count !== 16'd5)
            $display("FAIL stall_count: got stall=%b cnt=%0d want 0/5", stall, stall_count); else pass_cnt++;
        total_cnt++; if (tmr_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", tmr_ready); else pass_cnt++;
        tick();
        tmr_valid = 1'b0;
        total_cnt++; if (data_1_en !== 1'b1 || data_1 !== 16'h00AA || grant !== 2'b10)
            $display("FAIL stall_write: got en=%b d=%h g=%b want 1/00aa/10", data_1_en, data_1, grant); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b01; fib_valid = 1'b1; fib_data = 16'h0033;
        tick();
        tick();
        total_cnt++; if (data_1_en !== 1'b1) $display("FAIL mid_pre_en: got %b want 1", data_1_en); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (data_1_en !== 1'b0 || word_count !== 16'h0 || stall_count !== 16'h0)
            $display("FAIL mid_reset: got en=%b wc=%0d sc=%0d want 0/0/0", data_1_en, word_count, stall_count); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (fib_ready !== 1'b1) $display("FAIL mid_reaccept_ready: got %b want 1", fib_ready); else pass_cnt++;
        tick();
        fib_valid = 1'b0;
        total_cnt++; if (data_1_en !== 1'b1 || data_1 !== 16'h0033 || word_count !== 16'd1)
            $display("FAIL mid_rewrite: got en=%b d=%h wc=%0d want 1/0033/1", data_1_en, data_1, word_count); else pass_cnt++;
    endtask

    task automatic test_disabled_source();
        logic seen;
        do_reset();
        mode = 2'b01; tmr_valid = 1'b1; tmr_data = 16'h0077;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tmr_ready !== 1'b0 || data_1_en !== 1'b0) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL dis_blocked: got ready/write want none"); else pass_cnt++;
        mode = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (data_1_en === 1'b1) seen = 1'b1;
        end
        tmr_valid = 1'b0;
        total_cnt++; if (!seen || data_1 !== 16'h0077 || grant !== 2'b10)
            $display("FAIL dis_switch: got seen=%b d=%h g=%b want 1/0077/10", seen, data_1, grant); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        mode = 2'b10; tmr_valid = 1'b1; buffer_full = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) tick();
        total_cnt++; if (n_stall_count !== 4'hF || stall_count !== 16'd15)
            $display("FAIL sat_reach: got n=%h w=%0d want f/15", n_stall_count, stall_count); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (n_stall_count !== 4'hF || stall_count !== 16'd19)
            $display("FAIL sat_hold: got n=%h w=%0d want f/19", n_stall_count, stall_count); else pass_cnt++;
        mode = 2'b00; tmr_valid = 1'b0; buffer_full = 1'b0;
        tick();
        total_cnt++; if (stall !== 1'b0 || n_stall_count !== 4'hF)
            $display("FAIL sat_exit: got stall=%b n=%h want 0/f", stall, n_stall_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_fib();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_disabled_source();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wr_arbiter.md
Name: wr_arbiter

Overview:
- Sits between the two 16-bit producers (Fibonacci, Timer) and the write side of the clock-domain-crossing buffer, on the fast clock domain.
- Selects one producer per transfer and drives the buffer's write enable and write data.
- Honours the buffer-full flag so that no word is ever dropped.
- Exposes a stall flag and throughput/stall counters for the top level.

Parameters:
- CNT_W, 16, width of word_count and stall_count.

Ports:
- clk_1 in 1: fast system clock; all logic is on its rising edge.
- rst_n in 1: asynchronous, active-low reset.
- mode in 2: source mode. 00 = off, 01 = Fibonacci only, 10 = Timer only, 11 = round-robin.
- fib_valid in 1: Fibonacci word available. Held with fib_data until accepted.
- fib_data in 16: Fibonacci word.
- fib_ready out 1: Fibonacci word accepted this cycle.
- tmr_valid in 1: Timer word available. Held with tmr_data until accepted.
- tmr_data in 16: Timer word.
- tmr_ready out 1: Timer word accepted this cycle.
- buffer_full in 1: buffer full flag, synchronous to clk_1.
- data_1_en out 1: write enable to the buffer.
- data_1 out 16: write data to the buffer.
- grant out 2: one-hot source of the current data_1. Bit0 = Fibonacci, bit1 = Timer.
- stall out 1: high while a producer is blocked by buffer_full.
- word_count out CNT_W: number of accepted words.
- stall_count out CNT_W: number of stalled cycles.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, last_grant = Timer, so the first round-robin tie goes to Fibonacci.
  - data_1_en = 0, data_1 = 0, grant = 00, stall = 0, word_count = 0, stall_count = 0.
  - The ready outputs are 0 in every state except ARB.
- Reset mid-transfer aborts the transfer. The word is neither written nor counted; the producer keeps valid asserted and re-offers it after reset.
- Enabled requester:
  - fib is enabled when mode[0]=1; tmr is enabled when mode[1]=1.
  - A request = enabled AND valid.
- Accept condition:
  - Only in ARB, only when buffer_full=0, and at most one producer per cycle.
  - x_ready is combinational from state, buffer_full, mode, the valids and last_grant.
  - A transfer happens on the clk_1 edge where x_valid and x_ready are both 1.
- Selection:
  - Only one requester: grant it.
  - Both request in round-robin mode: grant the one that is not last_grant.
  - last_grant updates on every accept.
- Latency:
  - Accept at edge N.
  - data_1 = accepted word, data_1_en = 1 and grant = source, all during cycle N+1 (registered).
  - data_1_en is a single-cycle pulse.
  - data_1 and grant hold their values afterwards; only data_1_en returns to 0.
- Write spacing:
  - No accept is allowed in the cycle in which data_1_en=1, so writes are at least 2 cycles apart.
  - This guarantees buffer_full reflects the previous write before the next accept. The buffer must never see data_1_en=1 while full.
- FSM:
  - IDLE: stay while mode=00, otherwise go to ARB.
  - ARB:
    - mode=00: go to IDLE.
    - buffer_full=1 and any request: go to HOLD.
    - Accept: go to WRITE.
    - Otherwise stay.
  - WRITE: data_1_en=1 for one cycle, then ARB (IDLE if mode=00).
  - HOLD:
    - stall=1; stall_count increments each cycle, saturating at all-ones.
    - buffer_full=0: go to ARB.
    - mode=00: go to IDLE (stall clears).
- Counters:
  - word_count increments by 1 on each accept and wraps modulo 2^CNT_W.
  - stall_count saturates at all-ones.
- Mode change:
  - Sampled every cycle. A word already accepted (WRITE) always completes.
  - Disabling a source while it is valid leaves that word pending, unaccepted, in the producer.
- Boundary cases:
  - buffer_full and a request rising in the same ARB cycle: no accept, go to HOLD.
  - buffer_full falling in HOLD: go to ARB next cycle, so the earliest accept is one cycle after buffer_full falls.
  - A valid dropped before acceptance is not recorded.

Test Plan:
- Reset, then mode=01, fib_valid=1, fib_data=0x0005, buffer_full=0.
  - fib_ready=1 in the first ARB cycle.
  - The next cycle shows data_1_en=1, data_1=0x0005, grant=01.
  - word_count=1.
- mode=11, both valid continuously (fib 0x0001, tmr 0x00AA), buffer_full=0.
  - Writes alternate fib, tmr, fib, tmr.
  - data_1_en is never high on two consecutive cycles.
  - word_count=4 after 8 cycles of operation.
- mode=10, tmr_valid=1, buffer_full held 1 for 5 cycles, then 0.
  - stall=1 for those 5 cycles and stall_count=5.
  - tmr_ready=0 throughout.
  - Accept follows one cycle after the release.
- Accept at edge N, rst_n driven low in cycle N+1.
  - data_1_en=0 immediately and both counters are 0.
  - The word is re-accepted after reset release.
- mode=01, tmr_valid=1 only.
  - tmr_ready is never asserted and there is no write.
  - Switching to mode=10 gives an accept within 2 cycles.
- Force stall_count to 0xFFFE, then hold in HOLD for 3 cycles.
  - stall_count = 0xFFFF and stays there.
